// File: rtl/des_pkg.sv
// Shared DES definitions: S-box tables, group/nibble types and the FSM state type.
package des_pkg;

    typedef logic [5:0] group_t;
    typedef logic [3:0] nibble_t;
    typedef logic [2:0] box_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Eight S-boxes, 64 nibbles each, written row-major (row 0 col 0 first).
    // The leftmost 256-bit block is S1, so S1 lands at the highest packed index.
    localparam logic [7:0][63:0][3:0] S_BOX_TABLES = {
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    // Row = outer bits {b5,b0}, column = b4..b1; the table is stored with the
    // first-written entry at the top, hence the inverted indices.
    function automatic nibble_t s_box_value(input box_idx_t box, input group_t grp);
        logic [5:0] addr;
        addr = {grp[5], grp[0], grp[4:1]};
        return S_BOX_TABLES[~box][~addr];
    endfunction

endpackage

// File: rtl/s_box_lookup.sv
// Single combinational S-box lookup: box index plus 6-bit group in, nibble out.
module s_box_lookup
    import des_pkg::*;
(
    input  logic [2:0] i_box,
    input  logic [5:0] i_group,
    output logic [3:0] o_nibble
);

    // Pure table lookup, no state.
    always_comb begin
        o_nibble = s_box_value(i_box, i_group);
    end

endmodule

// File: rtl/s_box_layer_seq.sv
// Sequential DES S-box layer: processes LANES groups per cycle over 8/LANES
// cycles, then holds the 32-bit result under a valid/ready handshake.
module s_box_layer_seq
    import des_pkg::*;
#(
    parameter int LANES   = 8,
    parameter int OUT_REG = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [47:0] s_box_input,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] s_box_output,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy
);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_badLanes
        $error("s_box_layer_seq: LANES must be 1, 2, 4 or 8");
    end

    localparam bit         HAS_OUT_REG = (OUT_REG != 0);
    localparam logic [3:0] LANE_STEP   = 4'(LANES);
    localparam logic [3:0] LAST_IDX    = 4'(8 - LANES);
    localparam logic [3:0] DONE_IDX    = 4'd8;

    state_t      r_state;
    state_t      w_nextState;
    logic [3:0]  r_idx;
    logic [47:0] r_input;
    logic [31:0] r_result;
    logic        r_started;
    logic        w_accept;
    logic        w_groupsDone;
    logic        w_lastStep;
    box_idx_t    w_box    [LANES];
    nibble_t     w_nibble [LANES];

    assign w_accept     = in_valid && in_ready;
    assign w_groupsDone = (r_idx == DONE_IDX);
    assign w_lastStep   = (r_idx == LAST_IDX);

    // The captured input shifts left each RUN cycle, so lane j always reads a
    // fixed slice; only the box index depends on the running group index.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign w_box[j] = r_idx[2:0] + 3'(j);
        s_box_lookup u_lookup (
            .i_box    (w_box[j]),
            .i_group  (r_input[47 - 6*j -: 6]),
            .o_nibble (w_nibble[j])
        );
    end

    // Holds in_ready low until the first clock after reset is released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_started <= 1'b0;
        end else begin
            r_started <= 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state and handshake outputs. With the output stage, RUN keeps one
    // extra cycle after the last group so the output register can load.
    always_comb begin
        w_nextState = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b1;
        case (r_state)
            IDLE: begin
                busy     = 1'b0;
                in_ready = r_started;
                if (in_valid && r_started) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                if ((HAS_OUT_REG && w_groupsDone) || (!HAS_OUT_REG && w_lastStep)) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Capture on accept, then write LANES nibbles per RUN cycle until all
    // eight groups are done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx    <= 4'd0;
            r_input  <= 48'h0;
            r_result <= 32'h0;
        end else if (w_accept) begin
            r_idx    <= 4'd0;
            r_input  <= s_box_input;
            r_result <= 32'h0;
        end else if (r_state == RUN && !w_groupsDone) begin
            for (int j = 0; j < LANES; j++) begin
                r_result[{~w_box[j], 2'b00} +: 4] <= w_nibble[j];
            end
            r_input <= r_input << (6 * LANES);
            r_idx   <= r_idx + LANE_STEP;
        end
    end

    if (HAS_OUT_REG) begin : g_outReg
        logic [31:0] r_outWord;

        // Output stage loads once per operation, in the cycle after the last group.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_outWord <= 32'h0;
            end else if (r_state == RUN && w_groupsDone) begin
                r_outWord <= r_result;
            end
        end

        assign s_box_output = r_outWord;
    end else begin : g_noOutReg
        assign s_box_output = r_result;
    end

endmodule

// File: tb/tb_s_box_layer_seq.sv
// Directed and random checks for s_box_layer_seq across LANES/OUT_REG settings.
module tb_s_box_layer_seq;

    localparam int NUM_DUT = 5;
    localparam int LANES_CFG [NUM_DUT] = '{1, 2, 4, 8, 4};
    localparam int OREG_CFG  [NUM_DUT] = '{1, 1, 1, 1, 0};

    // Independent reference tables: [box][row], column 0 in the top nibble.
    localparam logic [63:0] SBOX_ROWS [8][4] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD70934A6285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    logic        clk;
    logic        rst_n;
    logic [47:0] sIn      [NUM_DUT];
    logic        inValid  [NUM_DUT];
    logic        inReady  [NUM_DUT];
    logic [31:0] sOut     [NUM_DUT];
    logic        outValid [NUM_DUT];
    logic        outReady [NUM_DUT];
    logic        busyS    [NUM_DUT];

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    for (genvar k = 0; k < NUM_DUT; k++) begin : g_dut
        s_box_layer_seq #(
            .LANES   (LANES_CFG[k]),
            .OUT_REG (OREG_CFG[k])
        ) u_dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .s_box_input  (sIn[k]),
            .in_valid     (inValid[k]),
            .in_ready     (inReady[k]),
            .s_box_output (sOut[k]),
            .out_valid    (outValid[k]),
            .out_ready    (outReady[k]),
            .busy         (busyS[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] refModel(input logic [47:0] x);
        logic [31:0] res;
        logic [5:0]  g;
        logic [63:0] rowBits;
        int          row;
        int          col;
        res = 32'h0;
        for (int b = 0; b < 8; b++) begin
            g       = x[47 - 6*b -: 6];
            row     = int'({g[5], g[0]});
            col     = int'(g[4:1]);
            rowBits = SBOX_ROWS[b][row];
            res[31 - 4*b -: 4] = rowBits[63 - 4*col -: 4];
        end
        return res;
    endfunction

    function automatic int latOf(input int k);
        return 8 / LANES_CFG[k] + OREG_CFG[k];
    endfunction

    task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for in_ready, then presents one input for exactly the accept edge.
    task automatic applyStimulus(input int k, input logic [47:0] data);
        int n;
        n = 0;
        @(negedge clk);
        while (!inReady[k] && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("inReadyBeforeAccept", 48'(inReady[k]), 48'd1);
        sIn[k]     = data;
        inValid[k] = 1'b1;
        @(posedge clk);
        #1;
        inValid[k] = 1'b0;
    endtask

    task automatic waitResult(input int k, output int lat);
        lat = 0;
        while (!outValid[k] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic runTransaction(input int k, input logic [47:0] data, input logic [31:0] expected, input string tag);
        int lat;
        outReady[k] = 1'b1;
        applyStimulus(k, data);
        waitResult(k, lat);
        checkOutput({tag, "_latency"}, 48'(lat), 48'(latOf(k)));
        checkOutput({tag, "_data"}, 48'(sOut[k]), 48'(expected));
        checkOutput({tag, "_busy"}, 48'(busyS[k]), 48'd1);
        @(posedge clk);
        #1;
        checkOutput({tag, "_validDrop"}, 48'(outValid[k]), 48'd0);
    endtask

    // in_valid held high with fresh random data per accept; checks results
    // against the model and the spacing between consecutive accepts.
    task automatic streamRandom(input int k, input int count);
        logic [31:0] expQ [$];
        int          cyc;
        int          lastAcc;
        int          done;
        logic        acc;
        cyc         = 0;
        lastAcc     = -1;
        done        = 0;
        outReady[k] = 1'b1;
        @(negedge clk);
        sIn[k]     = {16'($urandom()), $urandom()};
        inValid[k] = 1'b1;
        while (done < count && cyc < count * 16) begin
            acc = inReady[k];
            @(posedge clk);
            #1;
            cyc++;
            if (acc) begin
                expQ.push_back(refModel(sIn[k]));
                if (lastAcc >= 0) begin
                    checkOutput("streamPeriod", 48'(cyc - lastAcc), 48'(latOf(k) + 2));
                end
                lastAcc = cyc;
                sIn[k]  = {16'($urandom()), $urandom()};
            end
            if (outValid[k]) begin
                checkOutput("streamPending", 48'(expQ.size()), 48'd1);
                if (expQ.size() > 0) begin
                    checkOutput("streamData", 48'(sOut[k]), 48'(expQ.pop_front()));
                end
                done++;
            end
            @(negedge clk);
        end
        inValid[k] = 1'b0;
        checkOutput("streamCount", 48'(done), 48'(count));
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] expWord;
        int          lat;

        rst_n = 1'b0;
        for (int k = 0; k < NUM_DUT; k++) begin
            sIn[k]      = 48'h0;
            inValid[k]  = 1'b0;
            outReady[k] = 1'b1;
        end

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rstOut", 48'(sOut[3]), 48'h0);
        checkOutput("rstValid", 48'(outValid[3]), 48'd0);
        checkOutput("rstReady", 48'(inReady[3]), 48'd0);
        checkOutput("rstBusy", 48'(busyS[3]), 48'd0);
        checkOutput("rstReadyNoReg", 48'(inReady[4]), 48'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_DUT; k++) begin
            checkOutput("readyAfterReset", 48'(inReady[k]), 48'd1);
        end

        // Directed vectors with hand-derived results.
        runTransaction(3, 48'h0, 32'hEFA72C4D, "lanes8Zero");
        runTransaction(0, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, "lanes1Ones");
        runTransaction(2, 48'h0400_0000_0000, 32'h0FA72C4D, "lanes4S1Row1");
        runTransaction(4, 48'h0000_0000_0020, 32'hEFA72C47, "noRegS8Row2");
        runTransaction(4, 48'h0, 32'hEFA72C4D, "noRegZero");

        // Consumer stalls for 5 cycles in HOLD.
        expWord     = refModel(48'h0123_4567_89AB);
        outReady[3] = 1'b0;
        applyStimulus(3, 48'h0123_4567_89AB);
        waitResult(3, lat);
        checkOutput("stallLatency", 48'(lat), 48'd2);
        for (int i = 0; i < 5; i++) begin
            inValid[3] = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("stallData", 48'(sOut[3]), 48'(expWord));
            checkOutput("stallValid", 48'(outValid[3]), 48'd1);
            checkOutput("stallReady", 48'(inReady[3]), 48'd0);
        end
        inValid[3]  = 1'b0;
        outReady[3] = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("releaseValid", 48'(outValid[3]), 48'd0);
        checkOutput("releaseBusy", 48'(busyS[3]), 48'd0);
        checkOutput("releaseReady", 48'(inReady[3]), 48'd1);

        // Input disturbed during RUN must not change the result or re-accept.
        expWord = refModel(48'hA5A5_5A5A_C3C3);
        applyStimulus(0, 48'hA5A5_5A5A_C3C3);
        for (int i = 0; i < 4; i++) begin
            sIn[0]     = {16'($urandom()), $urandom()};
            inValid[0] = 1'b1;
            @(posedge clk);
            #1;
            inValid[0] = 1'b0;
            @(posedge clk);
            #1;
        end
        waitResult(0, lat);
        checkOutput("disturbLatency", 48'(lat), 48'(latOf(0) - 8));
        checkOutput("disturbData", 48'(sOut[0]), 48'(expWord));
        @(posedge clk);
        #1;
        checkOutput("disturbBusyDrop", 48'(busyS[0]), 48'd0);
        @(posedge clk);
        #1;
        checkOutput("disturbNoReaccept", 48'(busyS[0]), 48'd0);

        // Reset in the middle of RUN with LANES=2.
        runTransaction(1, 48'hFFFF_FFFF_FFFF, 32'hD9CE3DCB, "lanes2Ones");
        applyStimulus(1, 48'h1357_9BDF_2468);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRunRstOut", 48'(sOut[1]), 48'h0);
        checkOutput("midRunRstValid", 48'(outValid[1]), 48'd0);
        checkOutput("midRunRstReady", 48'(inReady[1]), 48'd0);
        checkOutput("midRunRstBusy", 48'(busyS[1]), 48'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRunReadyRise", 48'(inReady[1]), 48'd1);
        runTransaction(1, 48'h0, 32'hEFA72C4D, "afterRstZero");

        // Back-to-back random traffic on every configuration.
        for (int k = 0; k < NUM_DUT; k++) begin
            streamRandom(k, 1000);
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
